// File: rtl/seq_detect_param.sv
// Serial pattern detector with loadable pattern, overlap control and match counter.
// Define SEQDET_COUNT_EN to build in match_count/count_sat; otherwise both are tied to 0.
module seq_detect_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             datain,
    input  logic             din_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             pattern_load,
    input  logic             overlap_en,
    output logic             dataout,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int FW = $clog2(PAT_W);
    localparam logic [FW-1:0] LAST = FW'(PAT_W - 1);

    typedef enum logic [1:0] {
        UNLOADED = 2'd0,
        FILL     = 2'd1,
        ARMED    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [PAT_W-1:0] window;
    logic             match;

    assign window = {hist_q, datain};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= UNLOADED;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (pattern_load) begin
            state_d = FILL;
            pat_d   = pattern;
            hist_d  = '0;
            fill_d  = '0;
        end else if (din_valid && state_q != UNLOADED) begin
            hist_d = window[PAT_W-2:0];
            if (match && !overlap_en) begin
                // Non-overlapping: the matched bits cannot seed the next match
                fill_d  = '0;
                state_d = FILL;
            end else begin
                fill_d  = (fill_q == LAST) ? fill_q : fill_q + FW'(1);
                state_d = (fill_d == LAST) ? ARMED : FILL;
            end
        end
    end

    always_comb begin
        match = (state_q == ARMED) && din_valid && !pattern_load
                && !reset && (window == pat_q);
        dataout = match;
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pattern_load) begin
            cnt_d = '0;
        end else if (match && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign match_count = cnt_q;
    assign count_sat   = &cnt_q;
`else
    assign match_count = '0;
    assign count_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed scoreboard bench for seq_detect_param (PAT_W=4; CNT_W=2 and CNT_W=8 instances).
module tb_seq_detect_param;

    logic       clock;
    logic       reset;
    logic       datain;
    logic       din_valid;
    logic [3:0] pattern;
    logic       pattern_load;
    logic       overlap_en;
    logic       dout_a, dout_b;
    logic [1:0] cnt_a;
    logic [7:0] cnt_b;
    logic       sat_a, sat_b;

    seq_detect_param #(.PAT_W(4), .CNT_W(2)) u_a (
        .clock(clock), .reset(reset), .datain(datain),
        .din_valid(din_valid), .pattern(pattern),
        .pattern_load(pattern_load), .overlap_en(overlap_en),
        .dataout(dout_a), .match_count(cnt_a), .count_sat(sat_a)
    );

    seq_detect_param #(.PAT_W(4), .CNT_W(8)) u_b (
        .clock(clock), .reset(reset), .datain(datain),
        .din_valid(din_valid), .pattern(pattern),
        .pattern_load(pattern_load), .overlap_en(overlap_en),
        .dataout(dout_b), .match_count(cnt_b), .count_sat(sat_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int n_hits = 0;

    // reference model state
    bit       m_loaded;
    bit [3:0] m_pat;
    bit       m_bits[$];
    int       m_cnt_a, m_cnt_b;

    bit       q_dout[$];
    int       q_cnt_a[$];
    int       q_cnt_b[$];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ld, input bit [3:0] p,
                        input bit v, input bit d, input string tag);
        bit       m;
        bit [3:0] win;
        int       ea, eb;
        @(negedge clock);
        reset        = rst;
        pattern_load = ld;
        pattern      = p;
        din_valid    = v;
        datain       = d;
        win = 4'(d);
        for (int i = 0; i < m_bits.size(); i++)
            win[3 - i] = m_bits[i];
        m = !rst && !ld && v && m_loaded && (m_bits.size() == 3)
            && (win == m_pat);
        q_dout.push_back(m);
        if (m) n_hits++;
        if (rst) begin
            m_loaded = 0; m_bits.delete(); m_cnt_a = 0; m_cnt_b = 0;
        end else if (ld) begin
            m_loaded = 1; m_pat = p; m_bits.delete();
            m_cnt_a = 0; m_cnt_b = 0;
        end else if (v && m_loaded) begin
            if (m && !overlap_en) begin
                m_bits.delete();
            end else begin
                m_bits.push_back(d);
                if (m_bits.size() > 3) void'(m_bits.pop_front());
            end
            if (m) begin
                if (m_cnt_a < 3) m_cnt_a++;
                if (m_cnt_b < 255) m_cnt_b++;
            end
        end
`ifdef SEQDET_COUNT_EN
        ea = m_cnt_a; eb = m_cnt_b;
`else
        ea = 0; eb = 0;
`endif
        q_cnt_a.push_back(ea);
        q_cnt_b.push_back(eb);
        #2;
        m = q_dout.pop_front();
        check({tag, ".dout_a"}, int'(dout_a), int'(m));
        check({tag, ".dout_b"}, int'(dout_b), int'(m));
        @(posedge clock);
        #1;
        ea = q_cnt_a.pop_front();
        eb = q_cnt_b.pop_front();
        check({tag, ".cnt_a"}, int'(cnt_a), ea);
        check({tag, ".cnt_b"}, int'(cnt_b), eb);
        check({tag, ".sat_a"}, int'(sat_a), int'(ea == 3));
        check({tag, ".sat_b"}, int'(sat_b), int'(eb == 255));
    endtask

    task automatic bits(input string tag, input bit b[$]);
        foreach (b[i]) step(0, 0, 4'h0, 1, b[i], tag);
    endtask

    task automatic load(input bit [3:0] p, input string tag);
        step(0, 1, p, 0, 0, tag);
    endtask

    initial begin
        reset = 1; datain = 0; din_valid = 0; pattern = 4'h0;
        pattern_load = 0; overlap_en = 1;

        step(1, 0, 4'h0, 0, 0, "rst0");
        step(1, 0, 4'h0, 1, 1, "rst1");
        bits("unloaded", '{1, 1, 0, 1});

        // overlapping detection
        overlap_en = 1;
        load(4'b1101, "ld_ov");
        bits("ov_a", '{1, 1, 1, 0, 1});
        bits("ov_b", '{1, 0, 1});
        bits("ov_c", '{0, 0});

        // non-overlapping detection
        overlap_en = 0;
        load(4'b1101, "ld_nov");
        bits("nov", '{1, 1, 0, 1, 1, 0, 1});

        // invalid-cycle gaps mid-pattern
        overlap_en = 1;
        load(4'b1101, "ld_gap");
        bits("gap_a", '{1, 1});
        step(0, 0, 4'h0, 0, 1, "gap0");
        step(0, 0, 4'h0, 0, 0, "gap1");
        step(0, 0, 4'h0, 0, 1, "gap2");
        bits("gap_b", '{0, 1});

        // load wins over a simultaneous valid bit
        bits("pre_ld", '{1, 1, 0});
        step(0, 1, 4'b1101, 1, 1, "ld_vld");
        bits("post_ld", '{1});

        // saturation on the narrow counter
        load(4'b1101, "ld_sat");
        for (int k = 0; k < 5; k++) bits("sat", '{1, 1, 0, 1});

        // reset mid-sequence, then datain ignored until a load
        bits("pre_rst", '{1, 1, 0});
        step(1, 0, 4'h0, 1, 1, "rst_mid");
        bits("post_rst", '{1, 1, 0, 1, 1, 0, 1});

        // reset has priority over load
        step(1, 1, 4'b1101, 1, 1, "rst_ld");
        bits("after_rl", '{1, 1, 0, 1});

        load(4'b0110, "ld_end");
        bits("end", '{0, 1, 1, 0, 1, 1, 0});

        n_chk++;
        assert (n_hits == 11) else begin
            n_fail++;
            $error("FAIL model_hits: observed %0d expected %0d", n_hits, 11);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL provide parameter PAT_W, default 4, pattern length in bits (legal 2..16).
REQ-002 SHALL provide parameter CNT_W, default 8, match-counter width in bits.
REQ-003 SHALL provide port clock  input  1  single rising-edge clock for all state.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port datain  input  1  serial data bit, sampled when din_valid=1.
REQ-006 SHALL provide port din_valid  input  1  qualifies datain for the current cycle.
REQ-007 SHALL provide port pattern  input  PAT_W  target sequence; pattern[PAT_W-1] is the first bit received, pattern[0] the last.
REQ-008 SHALL provide port pattern_load  input  1  captures pattern into an internal register.
REQ-009 SHALL provide port overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 SHALL provide port dataout  output  1  Mealy match flag, combinational from state and current inputs.
REQ-011 SHALL provide port match_count  output  CNT_W  number of matches since reset or the last load.
REQ-012 SHALL provide port count_sat  output  1  high while match_count is all-ones.

Function
REQ-013 SHALL hold a PAT_W-bit pattern register, a (PAT_W-1)-bit history shift register and a fill count of 0..PAT_W-1.
REQ-014 SHALL implement states UNLOADED (no pattern captured), FILL (fill < PAT_W-1) and ARMED (fill = PAT_W-1).
REQ-015 SHALL assert dataout only when all hold: state ARMED, din_valid=1, pattern_load=0, reset=0, and {history, datain} equals the pattern register.
REQ-016 SHALL produce zero latency: dataout rises in the same cycle the final pattern bit is presented.
REQ-017 SHALL, on a valid bit, shift datain into the history LSB and increment fill, saturating at PAT_W-1.
REQ-018 SHALL, when din_valid=0, hold history, fill, state and counter unchanged and drive dataout 0.
REQ-019 SHALL, on a match with overlap_en=1, shift normally so that the suffix of the match can begin the next match.
REQ-020 SHALL, on a match with overlap_en=0, clear fill to 0 and enter FILL.
REQ-021 SHALL, on pattern_load=1, capture pattern, clear history, fill and match_count, enter FILL, and ignore datain for that cycle.
REQ-022 SHALL give pattern_load priority over a simultaneous din_valid.
REQ-023 SHALL, in UNLOADED, ignore datain and drive dataout 0.
REQ-024 SHALL treat an overlap_en change as taking effect on the next match, with no state flush.
REQ-025 SHALL increment match_count by 1 on each cycle in which dataout=1.
REQ-026 SHALL saturate match_count at 2^CNT_W-1; it SHALL NOT wrap.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, clear the pattern register, history, fill and match_count, and enter UNLOADED.
REQ-028 SHALL drive dataout=0, match_count=0 and count_sat=0 while reset is high and after reset.
REQ-029 SHALL give reset priority over pattern_load and din_valid; a reset mid-sequence discards all partial progress.

Configuration
REQ-030 SHALL use macro SEQDET_COUNT_EN to compile the match counter in or out.
REQ-031 SHALL, with SEQDET_COUNT_EN defined, implement match_count and count_sat as specified.
REQ-032 SHALL, without SEQDET_COUNT_EN, keep both ports present, tie them to 0, and leave dataout behaviour unchanged.

Verification
REQ-033 SHALL check: PAT_W=4, load 1101, overlap_en=1, bits 1,1,1,0,1 -> dataout=1 only on the 5th bit; match_count=1.
REQ-034 SHALL check: continuing the REQ-033 stream with bits 1,0,1 -> dataout=1 on the 3rd bit (overlap); match_count=2; then bits 0,0 -> dataout=0.
REQ-035 SHALL check: overlap_en=0, load 1101, bits 1,1,0,1,1,0,1 -> dataout=1 on the 4th bit only; match_count=1.
REQ-036 SHALL check: din_valid low for 3 cycles between bits 2 and 3 of 1101 -> match still occurs on the 4th valid bit; dataout=0 during the gaps.
REQ-037 SHALL check: pattern_load together with din_valid after bits 1,1,0 -> no match on that cycle, fill=0; a following 1 gives no match.
REQ-038 SHALL check: CNT_W=2, 5 matches -> match_count=3, count_sat=1; reset -> all outputs 0, then datain is ignored until the next load.
